data_mem_responder: RTL and testbench

Memory-side responder for the ARM processor's load/store port. It accepts one word-wide read or write request at a time over a valid/ready handshake. It services the request from an internal single-port RAM after a programmable number of wait states, then returns a response over a second valid/ready handshake. It sits between the processor's ALU-result/write-data outputs and its read-data input, and is the slave end of the processor's data-memory interface.

---
 rtl/mem_pkg.sv | 13 +
 rtl/ram_sp.sv | 23 ++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned ADDR_W     = 32;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with a registered read port and no reset.
module ram_sp #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read-before-write: rdata shows the old word on a write edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Slave end of the processor data-memory port: one request at a time, serviced from a
// local RAM after a programmable number of wait states, answered over a response handshake.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned       DEPTH_WORDS = 256,
   parameter int unsigned       LATENCY     = 2,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_error
);

   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam int unsigned DATA_W = WORD_BYTES * 8;

   mem_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic [ADDR_W-1:0] offset;
   logic [IDX_W-1:0]  idx;
   logic              addr_err;
   logic              enter_resp;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   // Underflow is caught by the compare; the shifted offset catches the top of the window.
   assign offset     = addr_q - BASE_ADDR;
   assign idx        = offset[IDX_W+1:2];
   assign addr_err   = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                       ((offset >> (IDX_W + 2)) != '0);
   assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
   assign ram_we     = enter_resp && write_q && !addr_err;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            // Every request spends LATENCY+1 cycles in WAIT, so even LATENCY=0 gets a decode cycle.
            if (req_valid) begin
               state_d = WAIT;
               cnt_d   = 4'(LATENCY);
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if ((state_q == IDLE) && req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (enter_resp) begin
            err_q <= addr_err;
         end
      end
   end

   ram_sp #(
      .DEPTH (DEPTH_WORDS),
      .WIDTH (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (idx),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // The RAM address is held through RESP, so its output register stays stable until the handshake.
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_error = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !write_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a LATENCY=2 responder for function/timing, a LATENCY=0 one for request spacing.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] resp_rdata;

   logic        req_valid0 = 1'b0, req_write0 = 1'b0, resp_ready0 = 1'b1;
   logic [31:0] req_addr0 = '0, req_wdata0 = '0;
   logic        req_ready0, resp_valid0, resp_error0;
   logic [31:0] resp_rdata0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DEPTH_WORDS (256),
      .LATENCY     (2),
      .BASE_ADDR   (32'h0000_1000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error)
   );

   data_mem_responder #(
      .DEPTH_WORDS (256),
      .LATENCY     (0),
      .BASE_ADDR   (32'h0000_1000)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid0),
      .req_ready  (req_ready0),
      .req_write  (req_write0),
      .req_addr   (req_addr0),
      .req_wdata  (req_wdata0),
      .resp_valid (resp_valid0),
      .resp_ready (resp_ready0),
      .resp_rdata (resp_rdata0),
      .resp_error (resp_error0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request and wait for it to be accepted; returns after the accept edge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(n < 50), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // lat = edges after the accept edge before resp_valid is seen.
   task automatic wait_resp(output int lat);
      lat = 0;
      @(negedge clk);
      while (!resp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
      issue(w, a, d);
      wait_resp(lat);
      rd = resp_rdata;
      er = resp_error;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          accepts[$];
   int          first_resp;
   logic [31:0] bad_addr [3];
   string       bad_tag  [3];

   initial begin
      bad_addr[0] = 32'h0000_1002;  bad_tag[0] = "misaligned";
      bad_addr[1] = 32'h0000_0FFC;  bad_tag[1] = "below_base";
      bad_addr[2] = 32'h0000_1400;  bad_tag[2] = "above_top";

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_error", 32'(resp_error), 32'd0);

      // Store then load, LATENCY=2 -> response after edge N+3.
      xact(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, rd, er, lat);
      chk("st1008_err", 32'(er), 32'd0);
      chk("st1008_rdata", rd, 32'h0);
      chk("st1008_lat", 32'(lat), 32'd3);
      xact(1'b0, 32'h0000_1008, 32'h0, rd, er, lat);
      chk("ld1008_rdata", rd, 32'hDEAD_BEEF);
      chk("ld1008_err", 32'(er), 32'd0);
      chk("ld1008_lat", 32'(lat), 32'd3);

      // Word 0 baseline, then error stores/loads that must not touch it.
      xact(1'b1, 32'h0000_1000, 32'h1234_5678, rd, er, lat);
      chk("st1000_err", 32'(er), 32'd0);
      for (int i = 0; i < 3; i++) begin
         xact(1'b1, bad_addr[i], 32'hAAAA_5555, rd, er, lat);
         chk({bad_tag[i], "_st_err"}, 32'(er), 32'd1);
         chk({bad_tag[i], "_st_rdata"}, rd, 32'h0);
         xact(1'b0, bad_addr[i], 32'h0, rd, er, lat);
         chk({bad_tag[i], "_ld_err"}, 32'(er), 32'd1);
         chk({bad_tag[i], "_ld_rdata"}, rd, 32'h0);
         xact(1'b0, 32'h0000_1000, 32'h0, rd, er, lat);
         chk({bad_tag[i], "_word0"}, rd, 32'h1234_5678);
         chk({bad_tag[i], "_word0_err"}, 32'(er), 32'd0);
      end

      // Response backpressure for 10 cycles.
      issue(1'b0, 32'h0000_1008, 32'h0);
      wait_resp(lat);
      chk("bp_lat", 32'(lat), 32'd3);
      for (int i = 0; i < 10; i++) begin
         chk("bp_resp_valid", 32'(resp_valid), 32'd1);
         chk("bp_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #1 chk("bp_ready_same_cycle", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("bp_req_ready_after", 32'(req_ready), 32'd1);
      chk("bp_resp_valid_after", 32'(resp_valid), 32'd0);
      chk("bp_resp_rdata_after", resp_rdata, 32'h0);

      // Reset during WAIT drops the pending store.
      xact(1'b1, 32'h0000_1010, 32'h1111_0000, rd, er, lat);
      issue(1'b1, 32'h0000_1010, 32'h2222_0000);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rstwait_req_ready", 32'(req_ready), 32'd1);
      chk("rstwait_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      xact(1'b0, 32'h0000_1010, 32'h0, rd, er, lat);
      chk("rstwait_ld1010", rd, 32'h1111_0000);
      chk("rstwait_ld_err", 32'(er), 32'd0);

      // LATENCY=0 build: back-to-back requests with resp_ready held high.
      @(negedge clk);
      req_valid0 = 1'b1;
      req_write0 = 1'b1;
      req_addr0  = 32'h0000_1000;
      req_wdata0 = 32'h0000_0005;
      first_resp = -1;
      for (int i = 0; i < 12; i++) begin
         if (req_ready0) accepts.push_back(i);
         if (resp_valid0 && first_resp < 0) first_resp = i;
         @(negedge clk);
      end
      req_valid0 = 1'b0;
      chk("l0_accept_count", 32'(accepts.size()), 32'd4);
      for (int i = 1; i < accepts.size(); i++) begin
         chk("l0_spacing", 32'(accepts[i] - accepts[i-1]), 32'd3);
      end
      chk("l0_first_resp", 32'(first_resp), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
